// File: rtl/key_event_decoder_if.sv
// key_event_decoder_if: debouncer-side inputs and gesture pulse outputs of the key event decoder
interface key_event_decoder_if;
  logic key_flag;
  logic key_state;
  logic short_press;
  logic double_click;
  logic long_press;
  logic hold_repeat;
  logic busy;
  modport master (
    output key_flag, key_state,
    input  short_press, double_click, long_press, hold_repeat, busy
  );
  modport slave (
    input  key_flag, key_state,
    output short_press, double_click, long_press, hold_repeat, busy
  );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: classifies debounced key gestures into short/double/long/repeat pulses
module key_event_decoder #(
  parameter int LONG_CNT   = 50_000_000,
  parameter int DBL_CNT    = 15_000_000,
  parameter int REPEAT_CNT = 10_000_000,
  parameter int CNT_W      = 32
) (
  input logic               clk,
  input logic               rst,
  key_event_decoder_if.slave kbus
);
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, WAIT_REL, LONG_HOLD} state_t;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_timer, w_timer_next;
  logic             r_short, r_dbl, r_long, r_rep, r_busy;
  logic             w_short, w_dbl, w_long, w_rep;
  logic             w_press, w_rel, w_timed;
  assign w_press = kbus.key_flag & ~kbus.key_state;
  assign w_rel   = kbus.key_flag & kbus.key_state;
  assign w_timed = r_state inside {PRESS1, WAIT2, LONG_HOLD};
  // Events are tested before expiry so a strobe on the expiry cycle wins.
  always_comb begin
    w_state_next = r_state;
    w_short      = 1'b0;
    w_dbl        = 1'b0;
    w_long       = 1'b0;
    w_rep        = 1'b0;
    case (r_state)
      IDLE:      w_state_next = w_press ? PRESS1 : IDLE;
      PRESS1:
        if (w_rel) w_state_next = WAIT2;
        else if (r_timer == LONG_LAST) begin
          w_state_next = LONG_HOLD;
          w_long       = 1'b1;
        end
      WAIT2:
        if (w_press) begin
          w_state_next = WAIT_REL;
          w_dbl        = 1'b1;
        end else if (r_timer == DBL_LAST) begin
          w_state_next = IDLE;
          w_short      = 1'b1;
        end
      WAIT_REL:  w_state_next = w_rel ? IDLE : WAIT_REL;
      LONG_HOLD:
        if (w_rel) w_state_next = IDLE;
        else w_rep = (r_timer == REP_LAST);
      default:   w_state_next = IDLE;
    endcase
    w_timer_next = (w_state_next != r_state || w_rep || !w_timed) ? '0 : r_timer + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_short <= 1'b0;
      r_dbl   <= 1'b0;
      r_long  <= 1'b0;
      r_rep   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      r_short <= w_short;
      r_dbl   <= w_dbl;
      r_long  <= w_long;
      r_rep   <= w_rep;
      r_busy  <= (r_state != IDLE);
    end
  end
  assign kbus.short_press  = r_short;
  assign kbus.double_click = r_dbl;
  assign kbus.long_press   = r_long;
  assign kbus.hold_repeat  = r_rep;
  assign kbus.busy         = r_busy;
endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed gesture scenarios with hand-computed pulse cycles
module tb_key_event_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  key_event_decoder_if kbus();
  key_event_decoder #(.LONG_CNT(100), .DBL_CNT(40), .REPEAT_CNT(20), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .kbus(kbus)
  );
  always #10 clk = ~clk;
  int tests = 0;
  int fails = 0;
  int cyc, n_sp, n_dc, n_lp, n_hr, t_sp, t_dc, t_lp, t_bf, multi;
  int hr_t[$];
  logic prev_busy;
  task automatic clr();
    cyc = 0; n_sp = 0; n_dc = 0; n_lp = 0; n_hr = 0;
    t_sp = -1; t_dc = -1; t_lp = -1; t_bf = -1; multi = 0;
    hr_t.delete();
    prev_busy = kbus.busy;
  endtask
  // Drive one cycle of input, then record what the outputs show in the following cycle.
  task automatic step(input logic flag, input logic st);
    kbus.key_flag = flag;
    kbus.key_state = st;
    @(posedge clk);
    #1;
    kbus.key_flag = 1'b0;
    cyc++;
    if (kbus.short_press)  begin n_sp++; t_sp = cyc; end
    if (kbus.double_click) begin n_dc++; t_dc = cyc; end
    if (kbus.long_press)   begin n_lp++; t_lp = cyc; end
    if (kbus.hold_repeat)  begin n_hr++; hr_t.push_back(cyc); end
    if ($countones({kbus.short_press, kbus.double_click, kbus.long_press, kbus.hold_repeat}) > 1) multi++;
    if (prev_busy && !kbus.busy) t_bf = cyc;
    prev_busy = kbus.busy;
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1);
  endtask
  task automatic test_reset();
    logic [4:0] outs;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(i[0], 1'b0);
      outs = {kbus.short_press, kbus.double_click, kbus.long_press, kbus.hold_repeat, kbus.busy};
      tests++;
      if (outs !== 5'b0) begin fails++; $display("FAIL reset_outs[%0d]: got %b expected 00000", i, outs); end
    end
    rst = 1'b0;
    clr();
    idle(50);
    tests++;
    if (n_sp + n_dc + n_lp + n_hr !== 0) begin fails++; $display("FAIL reset_idle_pulses: got %0d expected 0", n_sp + n_dc + n_lp + n_hr); end
    tests++;
    if (kbus.busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy: got %b expected 0", kbus.busy); end
  endtask
  task automatic test_short_press();
    clr();
    step(1'b1, 1'b0);
    idle(29);
    step(1'b1, 1'b1);
    tests++;
    if (kbus.busy !== 1'b1) begin fails++; $display("FAIL short_busy_high: got %b expected 1", kbus.busy); end
    idle(45);
    tests++;
    if (n_sp !== 1) begin fails++; $display("FAIL short_count: got %0d expected 1", n_sp); end
    tests++;
    if (t_sp !== 71) begin fails++; $display("FAIL short_cycle: got %0d expected 71", t_sp); end
    tests++;
    if (n_dc + n_lp + n_hr !== 0) begin fails++; $display("FAIL short_others: got %0d expected 0", n_dc + n_lp + n_hr); end
    tests++;
    if (t_bf !== 72) begin fails++; $display("FAIL short_busy_fall: got %0d expected 72", t_bf); end
  endtask
  task automatic test_double_click();
    clr();
    step(1'b1, 1'b0);
    idle(9);
    step(1'b1, 1'b1);
    idle(24);
    step(1'b1, 1'b0);
    idle(9);
    step(1'b1, 1'b1);
    idle(50);
    tests++;
    if (n_dc !== 1) begin fails++; $display("FAIL dbl_count: got %0d expected 1", n_dc); end
    tests++;
    if (t_dc !== 36) begin fails++; $display("FAIL dbl_cycle: got %0d expected 36", t_dc); end
    tests++;
    if (n_sp + n_lp + n_hr !== 0) begin fails++; $display("FAIL dbl_others: got %0d expected 0", n_sp + n_lp + n_hr); end
    tests++;
    if (kbus.busy !== 1'b0) begin fails++; $display("FAIL dbl_busy_end: got %b expected 0", kbus.busy); end
  endtask
  task automatic test_long_press();
    int exp_hr[3] = '{121, 141, 161};
    clr();
    step(1'b1, 1'b0);
    idle(164);
    step(1'b1, 1'b1);
    idle(60);
    tests++;
    if (n_lp !== 1) begin fails++; $display("FAIL long_count: got %0d expected 1", n_lp); end
    tests++;
    if (t_lp !== 101) begin fails++; $display("FAIL long_cycle: got %0d expected 101", t_lp); end
    tests++;
    if (n_hr !== 3) begin fails++; $display("FAIL repeat_count: got %0d expected 3", n_hr); end
    for (int i = 0; i < 3 && i < n_hr; i++) begin
      tests++;
      if (hr_t[i] !== exp_hr[i]) begin fails++; $display("FAIL repeat_cycle[%0d]: got %0d expected %0d", i, hr_t[i], exp_hr[i]); end
    end
    tests++;
    if (multi !== 0) begin fails++; $display("FAIL long_exclusive: got %0d overlapping cycles expected 0", multi); end
    tests++;
    if (n_sp + n_dc !== 0) begin fails++; $display("FAIL long_others: got %0d expected 0", n_sp + n_dc); end
    tests++;
    if (kbus.busy !== 1'b0) begin fails++; $display("FAIL long_busy_end: got %b expected 0", kbus.busy); end
  endtask
  task automatic test_boundary();
    for (int rc = 99; rc <= 100; rc++) begin
      clr();
      step(1'b1, 1'b0);
      idle(rc - 1);
      step(1'b1, 1'b1);
      idle(60);
      tests++;
      if (n_lp !== 0) begin fails++; $display("FAIL bound_rel%0d_long: got %0d expected 0", rc, n_lp); end
      tests++;
      if (t_sp !== rc + 41) begin fails++; $display("FAIL bound_rel%0d_short: got %0d expected %0d", rc, t_sp, rc + 41); end
    end
    for (int d = 39; d <= 40; d++) begin
      clr();
      step(1'b1, 1'b0);
      idle(9);
      step(1'b1, 1'b1);
      idle(d - 1);
      step(1'b1, 1'b0);
      idle(4);
      step(1'b1, 1'b1);
      idle(50);
      tests++;
      if (t_dc !== 11 + d) begin fails++; $display("FAIL bound_dbl%0d_cycle: got %0d expected %0d", d, t_dc, 11 + d); end
      tests++;
      if (n_sp !== 0) begin fails++; $display("FAIL bound_dbl%0d_short: got %0d expected 0", d, n_sp); end
    end
  endtask
  task automatic test_noise_reset();
    clr();
    step(1'b1, 1'b1);
    tests++;
    if (kbus.busy !== 1'b0) begin fails++; $display("FAIL noise_idle_rel_busy: got %b expected 0", kbus.busy); end
    step(1'b1, 1'b0);
    idle(19);
    step(1'b1, 1'b0);
    idle(90);
    step(1'b1, 1'b1);
    idle(50);
    tests++;
    if (t_lp !== 102) begin fails++; $display("FAIL noise_long_cycle: got %0d expected 102", t_lp); end
    tests++;
    if (n_lp + n_sp + n_dc + n_hr !== 1) begin fails++; $display("FAIL noise_pulse_total: got %0d expected 1", n_lp + n_sp + n_dc + n_hr); end
    clr();
    step(1'b1, 1'b0);
    idle(49);
    rst = 1'b1;
    step(1'b0, 1'b1);
    rst = 1'b0;
    tests++;
    if (kbus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", kbus.busy); end
    idle(100);
    tests++;
    if (n_lp + n_sp + n_dc + n_hr !== 0) begin fails++; $display("FAIL midrst_pulses: got %0d expected 0", n_lp + n_sp + n_dc + n_hr); end
    clr();
    step(1'b1, 1'b0);
    idle(19);
    step(1'b1, 1'b1);
    idle(45);
    tests++;
    if (t_sp !== 61 || n_sp !== 1) begin fails++; $display("FAIL midrst_next_short: got cycle %0d count %0d expected cycle 61 count 1", t_sp, n_sp); end
  endtask
  initial begin
    kbus.key_flag = 1'b0;
    kbus.key_state = 1'b1;
    clr();
    test_reset();
    test_short_press();
    test_double_click();
    test_long_press();
    test_boundary();
    test_noise_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Sits directly downstream of the key debouncer. Consumes its debounced edge strobe `key_flag` and level `key_state`.
- Classifies each gesture as short press, double click, or long press. Emits auto-repeat strobes while a long press is held.
- Outputs are single-cycle pulses for LED/counter/menu logic on the 50 MHz board clock.

Parameters:
- LONG_CNT, 50_000_000: cycles a press must be held to count as long (1 s at 50 MHz).
- DBL_CNT, 15_000_000: cycles after the first release in which a second press makes a double click (300 ms).
- REPEAT_CNT, 10_000_000: cycles between hold_repeat pulses while a long press is held (200 ms).
- CNT_W, 32: timer width; must hold max(LONG_CNT, DBL_CNT, REPEAT_CNT).

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous reset, active-high.
- key_flag  in  1  one-cycle strobe from the debouncer on each confirmed edge.
- key_state  in  1  debounced level, sampled when key_flag=1: 0 = press confirmed, 1 = release confirmed.
- short_press  out  1  one-cycle pulse: single click recognised.
- double_click  out  1  one-cycle pulse: second press within DBL_CNT.
- long_press  out  1  one-cycle pulse: press held LONG_CNT cycles.
- hold_repeat  out  1  one-cycle pulse every REPEAT_CNT cycles after long_press, until release.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Events:
  - press_ev = key_flag & ~key_state.
  - rel_ev = key_flag & key_state.
  - key_state is ignored when key_flag=0.
- Reset:
  - FSM goes to IDLE, timer = 0.
  - All outputs are 0 on the first clk edge with rst=1 and stay 0 while rst is held.
  - Reset mid-gesture discards the gesture; no pulse is emitted.
- Timer:
  - Clears to 0 on every state entry and increments each cycle in the timed states.
  - "Expires" means timer == N-1 in the current cycle.
- States and transitions:
  - IDLE: press_ev -> PRESS1. rel_ev is ignored.
  - PRESS1 (held, timing LONG_CNT):
    - rel_ev -> WAIT2.
    - On expiry -> LONG_HOLD and pulse long_press.
    - A repeated press_ev is ignored.
  - WAIT2 (released, timing DBL_CNT):
    - press_ev -> WAIT_REL and pulse double_click.
    - On expiry -> IDLE and pulse short_press.
  - WAIT_REL (second press held):
    - rel_ev -> IDLE.
    - No timing; no long_press is generated from a double click.
  - LONG_HOLD (timing REPEAT_CNT):
    - On expiry, pulse hold_repeat and restart the timer at 0 without leaving the state.
    - rel_ev -> IDLE, with no further pulses.
- Output timing:
  - All outputs are registered.
  - A pulse is high for exactly one cycle, the cycle after the deciding condition (event strobe or expiry).
- busy: registered, equal to (state != IDLE) one cycle after the state register updates.
- Simultaneous event and expiry in the same cycle: the event wins.
  - PRESS1: rel_ev on the expiry cycle -> WAIT2, no long_press.
  - WAIT2: press_ev on the expiry cycle -> double_click, no short_press.
- Pulse exclusivity: at most one of short_press, double_click, long_press, hold_repeat is high in any cycle.
- Latency:
  - short_press: DBL_CNT+1 cycles after the release strobe.
  - long_press: LONG_CNT+1 cycles after the press strobe.
- Parameter legality: each count must be >= 2. Smaller values are unsupported and need not be checked.

Test Plan:
Bench settings: LONG_CNT=100, DBL_CNT=40, REPEAT_CNT=20, clk period 20 ns, key_flag/key_state driven directly.
- Reset: rst=1 for 5 cycles with key_flag toggling -> all outputs 0, busy=0. After release of rst, idle for 50 cycles -> no pulses.
- Short press: press strobe, release strobe 30 cycles later -> exactly one short_press, 41 cycles after the release strobe. busy drops the cycle after.
- Double click: press; release at +10; press at +25 after the release; release at +10 -> one double_click, the cycle after the second press strobe. No short_press; busy=0 after the final release.
- Long press with repeat: press held 165 cycles -> long_press at cycle 101, hold_repeat at cycles 121, 141, 161. None after the release strobe. Only one pulse high per cycle.
- Boundary collisions:
  - Release strobe exactly on cycle 99 after press -> WAIT2, no long_press.
  - Second press strobe exactly 39 cycles after release -> double_click, no short_press.
- Noise and mid-gesture reset:
  - Release strobe in IDLE and a duplicate press strobe in PRESS1 -> ignored; timing unchanged.
  - rst pulsed 50 cycles into PRESS1 -> no long_press; next press is classified normally.
